// File: rtl/pep9_bus_memory.sv
// -----------------------------------------------------------------------------
// pep9_bus_memory
//   Byte-addressed RAM behind a req/DoneMem handshake with programmable wait
//   states. Each request is one byte transfer, or one 16-bit big-endian word
//   transfer done as two byte cycles. Word addresses wrap modulo DEPTH.
//   Addresses >= DEPTH complete with err=1, write nothing and read 16'h0000.
//
//   Ports
//     Sysclk       in   1       system clock, rising edge
//     resetbar     in   1       asynchronous active-low reset
//     req          in   1       transfer request, sampled in IDLE or DONE
//     we           in   1       1 = write, 0 = read
//     word         in   1       1 = 16-bit word, 0 = byte
//     address      in   ADDR_W  byte address
//     DatatoWrite  in   16      write data; byte mode uses [7:0]
//     DatatoRead   out  16      read data; byte mode returns {8'h00, byte}
//     DoneMem      out  1       one-cycle completion pulse
//     busy         out  1       high while in WAIT/XFER_HI/XFER_LO
//     err          out  1       out-of-range flag, meaningful with DoneMem
// -----------------------------------------------------------------------------
module pep9_bus_memory #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH       = 65536,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [7:0]  INIT_BYTE   = 8'h00
) (
  input  logic              Sysclk,
  input  logic              resetbar,
  input  logic              req,
  input  logic              we,
  input  logic              word,
  input  logic [ADDR_W-1:0] address,
  input  logic [15:0]       DatatoWrite,
  output logic [15:0]       DatatoRead,
  output logic              DoneMem,
  output logic              busy,
  output logic              err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_XFER_HI,
    S_XFER_LO,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             we_q, word_q, oor_q;
  logic [IDX_W-1:0] idx_q;
  logic [15:0]      wdata_q;
  logic [7:0]       rd_hi_q;

  logic             start;
  logic             addr_oor;
  logic [IDX_W-1:0] lo_idx, acc_idx;
  logic [7:0]       rd_byte, wr_byte;
  logic             wr_en;
  logic [15:0]      rdata_d;
  logic             done_d, busy_d, err_d;

  // NOTE: the array is deliberately left out of the reset: contents survive
  // resetbar and only take INIT_BYTE at power-on, which also keeps it a RAM.
  logic [7:0] mem_q [DEPTH] = '{default: INIT_BYTE};

  // Only the start address is range-checked; with a full address space no
  // address can be out of range.
  if (DEPTH >= (1 << ADDR_W)) begin : g_full
    assign addr_oor = 1'b0;
  end else begin : g_partial
    assign addr_oor = (address >= ADDR_W'(DEPTH));
  end

  assign start = req && (state_q == S_IDLE || state_q == S_DONE);

  // Low byte of a word sits at (A+1) mod DEPTH.
  assign lo_idx  = (idx_q == IDX_W'(DEPTH - 1)) ? '0 : idx_q + IDX_W'(1);
  assign acc_idx = (state_q == S_XFER_LO) ? lo_idx : idx_q;
  assign rd_byte = mem_q[acc_idx];
  assign wr_byte = (state_q == S_XFER_LO || !word_q) ? wdata_q[7:0] : wdata_q[15:8];
  assign wr_en   = we_q && !oor_q && (state_q == S_XFER_HI || state_q == S_XFER_LO);

  // Next-state logic.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            state_d = S_XFER_HI;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(WAIT_STATES - 1)) state_d = S_XFER_HI;
      end
      S_XFER_HI: state_d = word_q ? S_XFER_LO : S_DONE;
      S_XFER_LO: state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic: computed from the upcoming state so every output is a flop.
  always_comb begin
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d inside {S_WAIT, S_XFER_HI, S_XFER_LO});
    err_d   = done_d && oor_q;
    rdata_d = DatatoRead;
    if (!we_q && !word_q && state_q == S_XFER_HI) begin
      rdata_d = oor_q ? 16'h0000 : {8'h00, rd_byte};
    end
    if (!we_q && state_q == S_XFER_LO) begin
      rdata_d = oor_q ? 16'h0000 : {rd_hi_q, rd_byte};
    end
  end

  // State register, request capture and registered outputs.
  always_ff @(posedge Sysclk or negedge resetbar) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!resetbar) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      word_q     <= 1'b0;
      oor_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rd_hi_q    <= '0;
      DatatoRead <= '0;
      DoneMem    <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      DatatoRead <= rdata_d;
      DoneMem    <= done_d;
      busy       <= busy_d;
      err        <= err_d;
      if (start) begin
        we_q    <= we;
        word_q  <= word;
        oor_q   <= addr_oor;
        idx_q   <= address[IDX_W-1:0];
        wdata_q <= DatatoWrite;
      end
      if (state_q == S_XFER_HI) rd_hi_q <= rd_byte;
    end
  end

  // One byte per transfer state; reset forces IDLE so an aborted word write
  // keeps only the bytes already committed.
  always_ff @(posedge Sysclk) begin
    if (wr_en) mem_q[acc_idx] <= wr_byte;
  end

endmodule

// File: tb/tb_pep9_bus_memory.sv
// -----------------------------------------------------------------------------
// tb_pep9_bus_memory
//   Directed bench for pep9_bus_memory. Two instances share all inputs: one
//   with the full 64 KiB space and one with DEPTH=4096 for range errors.
//   Both use WAIT_STATES=2, so byte latency is 3 edges and word latency 4.
// -----------------------------------------------------------------------------
module tb_pep9_bus_memory;

  logic        clk = 1'b0;
  logic        resetbar = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        word = 1'b0;
  logic [15:0] address = '0;
  logic [15:0] dw = '0;

  logic [15:0] rd_b, rd_s;
  logic        done_b, done_s, busy_b, busy_s, err_b, err_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pep9_bus_memory #(
    .ADDR_W(16), .DEPTH(65536), .WAIT_STATES(2), .INIT_BYTE(8'h00)
  ) dut_big (
    .Sysclk(clk), .resetbar(resetbar), .req(req), .we(we), .word(word),
    .address(address), .DatatoWrite(dw), .DatatoRead(rd_b),
    .DoneMem(done_b), .busy(busy_b), .err(err_b)
  );

  pep9_bus_memory #(
    .ADDR_W(16), .DEPTH(4096), .WAIT_STATES(2), .INIT_BYTE(8'h00)
  ) dut_small (
    .Sysclk(clk), .resetbar(resetbar), .req(req), .we(we), .word(word),
    .address(address), .DatatoWrite(dw), .DatatoRead(rd_s),
    .DoneMem(done_s), .busy(busy_s), .err(err_s)
  );

  // Issue one request and return the number of edges after the sampling edge
  // at which DoneMem was seen (0 = never within the budget).
  task automatic xfer(input logic w, input logic wd, input logic [15:0] a,
                      input logic [15:0] d, output int lat);
    @(posedge clk); #1;
    req = 1'b1; we = w; word = wd; address = a; dw = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done_b || done_s) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetbar = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({done_b, busy_b, err_b, rd_b} !== 19'h0) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b busy=%b err=%b rd=%h want all zero",
               done_b, busy_b, err_b, rd_b);
    end
    @(negedge clk);
    resetbar = 1'b1;
  endtask

  task automatic test_byte();
    int lat;
    xfer(1'b0, 1'b0, 16'h0005, 16'h0000, lat);
    checks++;
    if (rd_b !== 16'h0000) begin errors++; $display("FAIL init_read: got %h want 0000", rd_b); end
    xfer(1'b1, 1'b0, 16'h0000, 16'h0061, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL byte_wr_latency: got %0d want 3", lat); end
    checks++;
    if (err_b !== 1'b0) begin errors++; $display("FAIL byte_wr_err: got %b want 0", err_b); end
    @(posedge clk); #1;
    checks++;
    if ({done_b, busy_b} !== 2'b00) begin
      errors++; $display("FAIL done_one_cycle: got done=%b busy=%b want 0 0", done_b, busy_b);
    end
    xfer(1'b0, 1'b0, 16'h0000, 16'h0000, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL byte_rd_latency: got %0d want 3", lat); end
    checks++;
    if (rd_b !== 16'h0061) begin errors++; $display("FAIL byte_rd_data: got %h want 0061", rd_b); end
    checks++;
    if (err_b !== 1'b0) begin errors++; $display("FAIL byte_rd_err: got %b want 0", err_b); end
  endtask

  task automatic test_reset_mid_wait();
    bit seen;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; word = 1'b0; address = 16'h0000;
    @(posedge clk); #1;
    req = 1'b0;
    checks++;
    if ({busy_b, rd_b} !== {1'b1, 16'h0061}) begin
      errors++; $display("FAIL wait_busy: got busy=%b rd=%h want 1 0061", busy_b, rd_b);
    end
    resetbar = 1'b0;
    #1;
    checks++;
    if ({done_b, busy_b, err_b, rd_b} !== 19'h0) begin
      errors++;
      $display("FAIL reset_mid_wait: got done=%b busy=%b err=%b rd=%h want all zero",
               done_b, busy_b, err_b, rd_b);
    end
    @(negedge clk);
    resetbar = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done_b) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL aborted_no_done: got 1 want 0"); end
  endtask

  task automatic test_word();
    int lat;
    xfer(1'b1, 1'b1, 16'h0010, 16'hBEEF, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL word_wr_latency: got %0d want 4", lat); end
    xfer(1'b0, 1'b0, 16'h0010, 16'h0000, lat);
    checks++;
    if (rd_b !== 16'h00BE) begin errors++; $display("FAIL word_hi_byte: got %h want 00BE", rd_b); end
    xfer(1'b0, 1'b0, 16'h0011, 16'h0000, lat);
    checks++;
    if (rd_b !== 16'h00EF) begin errors++; $display("FAIL word_lo_byte: got %h want 00EF", rd_b); end
    xfer(1'b0, 1'b1, 16'h0010, 16'h0000, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL word_rd_latency: got %0d want 4", lat); end
    checks++;
    if (rd_b !== 16'hBEEF) begin errors++; $display("FAIL word_rd_data: got %h want BEEF", rd_b); end
  endtask

  task automatic test_wrap();
    int lat;
    xfer(1'b1, 1'b1, 16'hFFFF, 16'h1234, lat);
    checks++;
    if ({err_b, err_s} !== 2'b01) begin
      errors++; $display("FAIL wrap_err: got big=%b small=%b want 0 1", err_b, err_s);
    end
    xfer(1'b0, 1'b0, 16'hFFFF, 16'h0000, lat);
    checks++;
    if (rd_b !== 16'h0012) begin errors++; $display("FAIL wrap_hi: got %h want 0012", rd_b); end
    xfer(1'b0, 1'b0, 16'h0000, 16'h0000, lat);
    checks++;
    if (rd_b !== 16'h0034) begin errors++; $display("FAIL wrap_lo: got %h want 0034", rd_b); end
    xfer(1'b0, 1'b1, 16'hFFFF, 16'h0000, lat);
    checks++;
    if (rd_b !== 16'h1234) begin errors++; $display("FAIL wrap_word: got %h want 1234", rd_b); end
  endtask

  task automatic test_range();
    int lat;
    xfer(1'b1, 1'b0, 16'h0FFF, 16'h0077, lat);
    checks++;
    if (err_s !== 1'b0) begin errors++; $display("FAIL range_inrange_err: got %b want 0", err_s); end
    xfer(1'b1, 1'b1, 16'h1000, 16'hCAFE, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL range_wr_latency: got %0d want 4", lat); end
    checks++;
    if ({done_s, err_s, err_b} !== 3'b110) begin
      errors++;
      $display("FAIL range_wr_err: got done_s=%b err_s=%b err_b=%b want 1 1 0", done_s, err_s, err_b);
    end
    xfer(1'b0, 1'b0, 16'h0001, 16'h0000, lat);
    checks++;
    if (rd_s !== 16'h0000) begin errors++; $display("FAIL range_no_alias_write: got %h want 0000", rd_s); end
    xfer(1'b0, 1'b0, 16'h0FFF, 16'h0000, lat);
    checks++;
    if (rd_s !== 16'h0077) begin errors++; $display("FAIL range_edge_byte: got %h want 0077", rd_s); end
    xfer(1'b1, 1'b0, 16'h0100, 16'h0011, lat);
    checks++;
    if (rd_s !== 16'h0077) begin errors++; $display("FAIL write_holds_read: got %h want 0077", rd_s); end
    xfer(1'b0, 1'b0, 16'h1000, 16'h0000, lat);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL range_rd_latency: got %0d want 3", lat); end
    checks++;
    if ({err_s, rd_s} !== {1'b1, 16'h0000}) begin
      errors++; $display("FAIL range_rd: got err=%b rd=%h want 1 0000", err_s, rd_s);
    end
    checks++;
    if (rd_b !== 16'h00CA) begin errors++; $display("FAIL big_0x1000: got %h want 00CA", rd_b); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] pulses;
    logic [15:0] d3, d7;
    pulses = '0; d3 = '0; d7 = '0;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; word = 1'b0; address = 16'h0010;
    @(posedge clk); #1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      pulses[i-1] = done_b;
      if (i == 3) d3 = rd_b;
      if (i == 7) d7 = rd_b;
      if (i == 1) address = 16'h0011;
      if (i == 11) req = 1'b0;
    end
    checks++;
    if (pulses !== 12'h444) begin errors++; $display("FAIL b2b_pulses: got %b want 010001000100", pulses); end
    checks++;
    if (d3 !== 16'h00BE) begin errors++; $display("FAIL b2b_first_data: got %h want 00BE", d3); end
    checks++;
    if (d7 !== 16'h00EF) begin errors++; $display("FAIL b2b_second_data: got %h want 00EF", d7); end
  endtask

  task automatic test_reset_xfer_lo();
    int lat;
    xfer(1'b1, 1'b0, 16'h0021, 16'h005E, lat);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; word = 1'b1; address = 16'h0020; dw = 16'hA5C3;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy_b !== 1'b1) begin errors++; $display("FAIL xfer_lo_busy: got %b want 1", busy_b); end
    resetbar = 1'b0;
    #1;
    checks++;
    if ({done_b, busy_b} !== 2'b00) begin
      errors++; $display("FAIL reset_xfer_lo: got done=%b busy=%b want 0 0", done_b, busy_b);
    end
    @(negedge clk);
    @(negedge clk);
    resetbar = 1'b1;
    xfer(1'b0, 1'b0, 16'h0020, 16'h0000, lat);
    checks++;
    if (rd_b !== 16'h00A5) begin errors++; $display("FAIL abort_hi_committed: got %h want 00A5", rd_b); end
    xfer(1'b0, 1'b0, 16'h0021, 16'h0000, lat);
    checks++;
    if (rd_b !== 16'h005E) begin errors++; $display("FAIL abort_lo_kept: got %h want 005E", rd_b); end
    xfer(1'b0, 1'b1, 16'h0020, 16'h0000, lat);
    checks++;
    if (rd_b !== 16'hA55E) begin errors++; $display("FAIL abort_word: got %h want A55E", rd_b); end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_reset_mid_wait();
    test_word();
    test_wrap();
    test_range();
    test_back_to_back();
    test_reset_xfer_lo();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
